// File: rtl/im_loader.sv
// ============================================================================
//  Module   : im_loader
//  Purpose  : Boot-time instruction-memory writer. Parses a framed big-endian
//             byte stream (address, count, data words) into IM word writes.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module im_loader #(
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_WORDS = 2048,
    parameter int          IDX_W    = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             im_we,
    output logic [IDX_W-1:0] im_idx,
    output logic [31:0]      im_wdata,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_addr  = 3'd1;
    localparam logic [2:0] c_st_count = 3'd2;
    localparam logic [2:0] c_st_data  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;
    localparam logic [2:0] c_st_err   = 3'd5;

    localparam logic [32:0] c_words  = 33'(IM_WORDS);
    localparam logic [29:0] c_base_w = IM_BASE[31:2];

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [1:0]       r_bcnt;
    logic [23:0]      r_shift;
    logic [31:0]      r_addr;
    logic [IDX_W:0]   r_remain;
    logic [IDX_W-1:0] r_cur;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_wdata;
    logic             r_we;

    logic             w_busy;
    logic             w_last_wr;
    logic             w_hs;
    logic             w_byte4;
    logic [31:0]      w_word;
    logic [29:0]      w_off;
    logic [32:0]      w_end;
    logic             w_hdr_bad;

    assign w_busy    = (r_state == c_st_addr) || (r_state == c_st_count) ||
                       (r_state == c_st_data);
    // Remaining count is already decremented when the final write is on the bus.
    assign w_last_wr = (r_state == c_st_data) && r_we && (r_remain == '0);
    assign in_ready  = w_busy && !w_last_wr;
    assign w_hs      = in_valid && in_ready;
    assign w_byte4   = w_hs && (r_bcnt == 2'd3);
    assign w_word    = {r_shift, in_data};

    // Offset works on word addresses; misaligned A is rejected separately.
    assign w_off     = r_addr[31:2] - c_base_w;
    assign w_end     = {3'b000, w_off} + {1'b0, w_word};
    assign w_hdr_bad = (r_addr[1:0] != 2'b00) || (r_addr < IM_BASE) ||
                       (w_end > c_words);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle, c_st_done, c_st_err: begin
                if (start) w_next = c_st_addr;
            end
            c_st_addr: begin
                if (w_byte4) w_next = c_st_count;
            end
            c_st_count: begin
                if (w_byte4) begin
                    if (w_hdr_bad)            w_next = c_st_err;
                    else if (w_word == '0)    w_next = c_st_done;
                    else                      w_next = c_st_data;
                end
            end
            c_st_data: begin
                if (w_last_wr) w_next = c_st_done;
            end
            default: w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bcnt   <= '0;
            r_shift  <= '0;
            r_addr   <= '0;
            r_remain <= '0;
            r_cur    <= '0;
            r_idx    <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (start && !w_busy) r_bcnt <= '0;
            if (w_hs) begin
                r_bcnt  <= r_bcnt + 2'd1;
                r_shift <= w_word[23:0];
            end
            if (w_byte4) begin
                case (r_state)
                    c_st_addr: r_addr <= w_word;
                    c_st_count: begin
                        r_cur    <= w_off[IDX_W-1:0];
                        r_remain <= w_word[IDX_W:0];
                    end
                    c_st_data: begin
                        r_we     <= 1'b1;
                        r_idx    <= r_cur;
                        r_wdata  <= w_word;
                        r_cur    <= r_cur + 1'b1;
                        r_remain <= r_remain - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign im_we    = r_we;
    assign im_idx   = r_idx;
    assign im_wdata = r_wdata;
    assign cpu_hold = w_busy;
    assign done     = (r_state == c_st_done);
    assign error    = (r_state == c_st_err);

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ============================================================================
//  Module   : tb_im_loader
//  Purpose  : Self-checking bench for im_loader: vector table, hand sequences
//             and randomized frames against an arithmetic reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_im_loader;

    localparam logic [31:0] c_base  = 32'h0000_3000;
    localparam int          c_words = 2048;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        im_we;
    logic [10:0] im_idx;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    im_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .im_we    (im_we),
        .im_idx   (im_idx),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    int          rdy_bad = 0;
    int          hold_bad = 0;
    int          lat_bad = 0;
    time         hs_t = 0;
    logic [42:0] wq[$];
    logic [31:0] wbuf[16];

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      n;
        logic [3:0][31:0] w;
        logic             exp_ok;
        logic [10:0]      exp_idx0;
    } vec_t;

    vec_t tbl[8];

    always @(posedge clk) begin
        if (in_valid && in_ready) hs_t = $time;
    end

    always @(negedge clk) begin
        if (im_we) begin
            wq.push_back({im_idx, im_wdata});
            if (!cpu_hold) hold_bad++;
            if ($time - hs_t != 5) lat_bad++;
        end
        if (cpu_hold && !in_ready && !im_we) rdy_bad++;
        if (done && (cpu_hold || error)) hold_bad++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic note_fail(input string nm);
        n_total++;
        $display("FAIL %s: got timeout, expected DUT response", nm);
    endtask

    function automatic bit model_ok(input logic [31:0] a, input logic [31:0] n);
        longint la = {32'd0, a};
        longint ln = {32'd0, n};
        if (la % 4 != 0) return 1'b0;
        if (la < longint'(c_base)) return 1'b0;
        return ((la - longint'(c_base)) / 4 + ln) <= c_words;
    endfunction

    // Drives one byte after up to max_gap idle cycles; returns at the negedge after the handshake.
    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int t = 0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            note_fail("handshake");
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] a, input logic [31:0] n, input bit ok,
                             input int idx0, input int gap, input bit midstart,
                             input string nm);
        int t = 0;
        int nw;
        logic [31:0] wv;
        wq.delete();
        pulse_start();
        chk({nm, " hold"}, {61'd0, cpu_hold, done, error}, 64'b100);
        for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8], gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(n[31-8*i -: 8], gap);
            if (midstart && i == 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        if (ok) begin
            for (int w = 0; w < int'(n); w++) begin
                wv = wbuf[w];
                for (int b = 0; b < 4; b++) send_byte(wv[31-8*b -: 8], gap);
            end
        end
        while (!(done || error) && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (t >= 40) note_fail({nm, " end"});
        chk({nm, " status"}, {62'd0, done, error}, ok ? 64'b10 : 64'b01);
        chk({nm, " release"}, {63'd0, cpu_hold}, 64'd0);
        nw = ok ? int'(n) : 0;
        chk({nm, " nwrites"}, 64'(wq.size()), 64'(nw));
        for (int i = 0; i < nw && i < wq.size(); i++)
            chk({nm, " write"}, {21'd0, wq[i]}, {21'd0, 11'(idx0 + i), wbuf[i]});
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] n;
        bit          ok;
        int          idx0;
        int          sel;

        tbl[0] = '{32'h0000_3000, 32'd2, {32'h0, 32'h0, 32'h0000_0000, 32'h3C01_1234}, 1'b1, 11'd0};
        tbl[1] = '{32'h0000_4180, 32'd1, {32'h0, 32'h0, 32'h0, 32'h4200_0018}, 1'b1, 11'd1120};
        tbl[2] = '{32'h0000_3002, 32'd1, {32'h0, 32'h0, 32'h0, 32'h1111_1111}, 1'b0, 11'd0};
        tbl[3] = '{32'h0000_4FFC, 32'd1, {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF}, 1'b1, 11'd2047};
        tbl[4] = '{32'h0000_2FFC, 32'd1, {32'h0, 32'h0, 32'h0, 32'h2222_2222}, 1'b0, 11'd0};
        tbl[5] = '{32'h0000_4FFC, 32'd2, {32'h0, 32'h0, 32'h3333_3333, 32'h4444_4444}, 1'b0, 11'd0};
        tbl[6] = '{32'h0000_3000, 32'd0, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 11'd0};
        tbl[7] = '{32'hFFFF_FFFC, 32'hFFFF_FFFF, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b0, 11'd0};

        repeat (3) @(negedge clk);
        chk("reset outputs", {16'd0, in_ready, im_we, im_idx, im_wdata, cpu_hold, done, error}, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 4; i++) wbuf[i] = tbl[v].w[i];
            run_frame(tbl[v].addr, tbl[v].n, tbl[v].exp_ok, int'(tbl[v].exp_idx0), 0, v == 0,
                      $sformatf("vec%0d", v));
        end

        // Abort after two of four words; nothing further may be written.
        wq.delete();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA000_0000 + i;
        pulse_start();
        a = 32'h0000_3000;
        n = 32'd4;
        for (int i = 0; i < 4; i++) send_byte(a[31-8*i -: 8], 0);
        for (int i = 0; i < 4; i++) send_byte(n[31-8*i -: 8], 0);
        for (int w = 0; w < 2; w++) begin
            a = wbuf[w];
            for (int b = 0; b < 4; b++) send_byte(a[31-8*b -: 8], 0);
        end
        send_byte(8'hA0, 0);
        send_byte(8'h00, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort outputs", {16'd0, in_ready, im_we, im_idx, im_wdata, cpu_hold, done, error}, 64'd0);
        chk("abort nwrites", 64'(wq.size()), 64'd2);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort quiet", 64'(wq.size()), 64'd2);
        wbuf[0] = 32'h0BAD_F00D;
        wbuf[1] = 32'h1234_5678;
        run_frame(32'h0000_3100, 32'd2, 1'b1, 64, 0, 1'b0, "after abort");

        for (int r = 0; r < 24; r++) begin
            sel = int'($urandom_range(0, 4));
            n   = $urandom_range(0, 6);
            case (sel)
                0: a = c_base + 4 * $urandom_range(0, c_words - 1);
                1: a = c_base + 4 * (c_words - $urandom_range(1, 6));
                2: a = c_base + 4 * $urandom_range(0, 100) + $urandom_range(1, 3);
                3: a = c_base - 4 * $urandom_range(1, 8);
                default: a = $urandom & 32'hFFFF_FFFC;
            endcase
            for (int i = 0; i < 16; i++) wbuf[i] = $urandom;
            ok   = model_ok(a, n);
            idx0 = ok ? int'((a - c_base) / 4) : 0;
            run_frame(a, n, ok, idx0, 5, (r % 3) == 0, $sformatf("rnd%0d", r));
        end

        chk("in_ready gaps", 64'(rdy_bad), 64'd0);
        chk("hold rules", 64'(hold_bad), 64'd0);
        chk("write latency", 64'(lat_bad), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
